// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-stage requests onto one single-port memory.
// Data wins by default; a small guard hands the port to fetch after two back-to-back data grants.
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              d_rd_en,
    input  logic              d_wr_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    input  logic [31:0]       mem_rdata,
    output logic              freeze,
    output logic [1:0]        fsm_state
);

    // Handshake: a requester raises its request (if_req, d_rd_en/d_wr_en) with stable
    // address/data and holds it until its ready pulses for one cycle; requests are only
    // sampled in IDLE, and a request still high after ready is a new transaction.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    logic [1:0]        starve_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              wr_q;
    logic              fetch_q;
    logic              data_req;
    logic              grant_data;
    logic              grant_fetch;
    logic              last_access;

    assign data_req    = d_rd_en | d_wr_en;
    assign last_access = (state_q == ACCESS) && (cnt_q == 4'(MEM_LAT - 1));

    always_comb begin
        state_d     = state_q;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req && !(if_req && starve_q == 2'd2)) begin
                    grant_data = 1'b1;
                end else if (if_req) begin
                    grant_fetch = 1'b1;
                end
                if (grant_data || grant_fetch) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (last_access) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            starve_q <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            wr_q     <= 1'b0;
            fetch_q  <= 1'b0;
            if_rdata <= 32'd0;
            d_rdata  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ACCESS && !last_access) begin
                cnt_q <= cnt_q + 4'd1;
            end else begin
                cnt_q <= 4'd0;
            end
            if (grant_data) begin
                addr_q   <= d_addr;
                wdata_q  <= d_wdata;
                wr_q     <= d_wr_en;
                fetch_q  <= 1'b0;
                // Only data grants that made fetch wait count toward starvation.
                starve_q <= if_req ? starve_q + 2'd1 : 2'd0;
            end else if (grant_fetch) begin
                addr_q   <= if_addr;
                wdata_q  <= 32'd0;
                wr_q     <= 1'b0;
                fetch_q  <= 1'b1;
                starve_q <= 2'd0;
            end
            if (last_access && !wr_q) begin
                if (fetch_q) begin
                    if_rdata <= mem_rdata;
                end else begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_rd_en = (state_q == ACCESS) && !wr_q;
    assign mem_wr_en = (state_q == ACCESS) && wr_q;
    assign mem_addr  = (state_q == ACCESS) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = (state_q == ACCESS) ? wdata_q : 32'd0;
    assign if_ready  = (state_q == RESP) && fetch_q;
    assign d_ready   = (state_q == RESP) && !fetch_q;
    assign freeze    = (data_req && !d_ready) || (if_req && !if_ready);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=4): latency, priority, starvation guard,
// write-over-read, address alignment and reset abort, with a small read-only memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_rd_en;
    logic        d_wr_en;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_rdata;
    logic        freeze;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    int         grants;
    int         last_ready;
    logic [7:0] exp_g;

    mem_arbiter #(.MEM_LAT(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata),
        .freeze(freeze), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        case (a)
            32'h0000_0008: return 32'hE3A0_0014;
            32'h0000_0400: return 32'h1234_5678;
            32'h0000_1000: return 32'hCAFE_F00D;
            default:       return a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    // Garbage outside reads so a stray capture is visible.
    assign mem_rdata = mem_rd_en ? mem_lookup(mem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        d_rd_en = 1'b0; d_wr_en = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(fsm_state), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_readies", {30'd0, if_ready, d_ready}, 32'd0);
        chk("rst_mem_en", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_freeze", 32'(freeze), 32'd0);

        // Single fetch from 0x8
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h8;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("t1_rd_en_c%0d", c), 32'(mem_rd_en), 32'(c >= 1 && c <= 4));
            chk($sformatf("t1_wr_en_c%0d", c), 32'(mem_wr_en), 32'd0);
            chk($sformatf("t1_if_ready_c%0d", c), 32'(if_ready), 32'(c == 5));
            chk($sformatf("t1_freeze_c%0d", c), 32'(freeze), 32'(c <= 4));
            if (c == 1) chk("t1_mem_addr", mem_addr, 32'h8);
            if (c == 5) chk("t1_if_rdata", if_rdata, 32'hE3A0_0014);
            @(posedge clk); #1;
            if (c == 5) if_req = 1'b0;
        end

        // Fetch and data read together: data first, fetch afterwards
        if_req = 1'b1; if_addr = 32'h20; d_rd_en = 1'b1; d_addr = 32'h400;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            chk($sformatf("t2_d_ready_c%0d", c), 32'(d_ready), 32'(c == 5));
            chk($sformatf("t2_if_ready_c%0d", c), 32'(if_ready), 32'(c == 11));
            chk($sformatf("t2_rd_en_c%0d", c), 32'(mem_rd_en),
                32'((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
            if (c == 1) chk("t2_mem_addr_d", mem_addr, 32'h400);
            if (c == 7) chk("t2_mem_addr_f", mem_addr, 32'h20);
            if (c == 5) begin
                chk("t2_d_rdata", d_rdata, 32'h1234_5678);
                chk("t2_if_rdata_hold", if_rdata, 32'hE3A0_0014);
            end
            if (c == 11) begin
                chk("t2_if_rdata", if_rdata, 32'hA5A5_A585);
                chk("t2_d_rdata_hold", d_rdata, 32'h1234_5678);
            end
            @(posedge clk); #1;
            if (c == 5) d_rd_en = 1'b0;
            if (c == 11) if_req = 1'b0;
        end

        // Read and write together is a write
        d_rd_en = 1'b1; d_wr_en = 1'b1; d_addr = 32'h404; d_wdata = 32'hC000_0000;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("t3_wr_en_c%0d", c), 32'(mem_wr_en), 32'(c >= 1 && c <= 4));
            chk($sformatf("t3_rd_en_c%0d", c), 32'(mem_rd_en), 32'd0);
            chk($sformatf("t3_d_ready_c%0d", c), 32'(d_ready), 32'(c == 5));
            if (c == 1) begin
                chk("t3_mem_addr", mem_addr, 32'h404);
                chk("t3_mem_wdata", mem_wdata, 32'hC000_0000);
            end
            if (c == 5) chk("t3_d_rdata_hold", d_rdata, 32'h1234_5678);
            @(posedge clk); #1;
            if (c == 5) begin d_rd_en = 1'b0; d_wr_en = 1'b0; end
        end

        // Unaligned data read address is word-aligned on the memory side
        d_rd_en = 1'b1; d_addr = 32'h1003; d_wdata = 32'd0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 1) chk("t4_mem_addr", mem_addr, 32'h1000);
            if (c == 5) begin
                chk("t4_d_ready", 32'(d_ready), 32'd1);
                chk("t4_d_rdata", d_rdata, 32'hCAFE_F00D);
            end
            @(posedge clk); #1;
            if (c == 5) d_rd_en = 1'b0;
        end

        // Continuous contention: D, D, F, D, D, F with one grant every 6 cycles
        exp_q = '{8'h44, 8'h44, 8'h46, 8'h44, 8'h44, 8'h46};
        grants = 0;
        last_ready = -1;
        if_req = 1'b1; if_addr = 32'h8; d_rd_en = 1'b1; d_addr = 32'h400;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 2) chk("t5_freeze", 32'(freeze), 32'd1);
            chk($sformatf("t5_both_ready_c%0d", c), 32'(if_ready && d_ready), 32'd0);
            if (if_ready || d_ready) begin
                exp_g = exp_q.pop_front();
                chk($sformatf("t5_grant%0d", grants), d_ready ? 32'h44 : 32'h46, 32'(exp_g));
                chk($sformatf("t5_cycle%0d", grants), c, 5 + 6 * grants);
                grants++;
                last_ready = c;
            end
            if (grants == 6) break;
            @(posedge clk); #1;
        end
        chk("t5_grant_count", grants, 6);
        @(posedge clk); #1;
        if_req = 1'b0; d_rd_en = 1'b0;

        // Reset during a data read aborts it
        d_rd_en = 1'b1; d_addr = 32'h400;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk($sformatf("t6_rd_en_c%0d", c), 32'(mem_rd_en), 32'(c == 1 || c == 2));
            chk($sformatf("t6_d_ready_c%0d", c), 32'(d_ready), 32'd0);
            if (c == 2) chk("t6_freeze", 32'(freeze), 32'd1);
            if (c == 3) begin
                chk("t6_state", 32'(fsm_state), 32'd0);
                chk("t6_d_rdata", d_rdata, 32'd0);
                chk("t6_if_rdata", if_rdata, 32'd0);
            end
            @(posedge clk); #1;
            if (c + 1 == 2) rst = 1'b1;
            if (c + 1 == 3) begin rst = 1'b0; d_rd_en = 1'b0; end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
